uart_loopback_top: RTL and testbench
====================================

# uart_loopback_top

- 8N1 UART transmitter and receiver joined by an internal serial loopback.
- A byte written on the parallel side is serialized, received back and presented on `dout` with a sticky ready flag.
- Serves as the self-contained UART core and bring-up block for the serial subsystem; no external serial pins.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range ≥ 4, even.
- `clk` input 1: single clock; everything is on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `data_in` input 8: byte to transmit; sampled on the accepted `wr_en` cycle.
- `wr_en` input 1: write strobe; ignored while `busy`.
- `rdy_clr` input 1: clears `rdy` (synchronous).
- `rdy` output 1: sticky flag meaning a received byte is valid on `dout`.
- `busy` output 1: transmitter is sending a frame.
- `dout` output 8: last correctly received byte.

## Operation
- Frame format:
  - Idle line is high.
  - 1 start bit (low), then 8 data bits LSB first, then 1 stop bit (high).
- TX FSM has states IDLE, START, DATA, STOP.
  - IDLE: when `wr_en`=1, latch `data_in`, go to START, set `busy`.
  - START, DATA and STOP each hold their bit for `CLKS_PER_BIT` cycles.
  - DATA uses a 3-bit index that runs 0..7.
  - STOP: at the end of the bit, return to IDLE and clear `busy`.
  - `wr_en` while busy is dropped, not queued. The latched byte is unaffected.
- RX FSM has states IDLE, START, DATA, STOP and watches the internal serial line.
  - IDLE: a low level starts the frame and resets the cycle counter.
  - START: re-check the line at `CLKS_PER_BIT/2`. If it is high, treat as a glitch and go back to IDLE.
  - DATA: sample each bit at mid-bit (a full `CLKS_PER_BIT` apart) and shift into bit position 0..7.
  - STOP: sample the stop bit at mid-bit.
    - High: load `dout` and set `rdy`.
    - Low (framing error): discard the byte; `rdy` and `dout` are unchanged.
  - After the STOP sample, return to IDLE.
- `rdy` behaviour:
  - Stays high until `rdy_clr`.
  - A new byte completing while `rdy`=1 overwrites `dout` and `rdy` stays 1.
  - If set and clear happen in the same cycle, set wins.
- Reset values:
  - `busy`=0, `rdy`=0, `dout`=8'h00.
  - Serial line high; both FSMs in IDLE; all counters 0.
  - Reset mid-frame aborts both FSMs immediately.

## Timing
- Accept: `wr_en` high at edge N with `busy`=0. `busy`=1 after edge N, and the start bit drives the line from the same edge.
- `busy` stays high for exactly 10·`CLKS_PER_BIT` cycles.
- The earliest next accept is the edge on which `busy` is already 0.
- `rdy` rises about 9.5·`CLKS_PER_BIT`+2 cycles after accept, which is before `busy` falls.
- `rdy_clr` high at edge M gives `rdy`=0 after M, unless a set also occurs at M.
- The line is driven from a register; the TX-to-RX path adds one register stage and no synchronizer.
- `dout` and `rdy` update on the same edge.

## Configuration
- `UART_PARITY_EN` defined:
  - TX inserts an even-parity bit between data bit 7 and the stop bit, giving an 11-bit frame.
  - `busy` lasts 11·`CLKS_PER_BIT` cycles.
  - RX checks parity. On mismatch the byte is discarded exactly like a framing error.
- Not defined: plain 8N1 as above.

## Structure
- Package `uart_pkg` holds:
  - TX/RX state enum.
  - `DATA_BITS`=8.
  - Start and stop bit level constants.
  - Default `CLKS_PER_BIT`.
- One natural sub-module, `uart_rx`, holds the receive FSM, shift register and `rdy`/`dout` registers. TX logic stays in the top.

## Test plan
- Reset low then high: `busy`=0, `rdy`=0, `dout`=8'h00.
- Send 8'h41 → `busy` high for 10·`CLKS_PER_BIT` cycles; `rdy`=1 and `dout`=8'h41. After `rdy_clr`, `rdy`=0 on the next cycle.
- Send 8'h55, wait for `busy` to fall → `rdy`=1, `dout`=8'h55; sample the serial line to check LSB-first bit order.
- Pulse `wr_en` with 8'hFF mid-frame of 8'h0F → ignored; only 8'h0F is received and `busy` length is unchanged.
- Send 8'hA5 then 8'h3C without clearing → `rdy` stays 1, `dout`=8'h3C. Assert `rdy_clr` in the set cycle → `rdy` stays 1.
- Assert reset mid-frame → `busy`=0 and `rdy`=0 immediately; no spurious byte afterwards. With `UART_PARITY_EN`, repeat 8'h41 → 11-bit frame, correct receipt.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART loopback core.
//   uart_state_e         : state encoding used by both the TX and RX FSMs
//   DATA_BITS            : payload bits per frame
//   START_BIT / STOP_BIT : serial line levels for the framing bits
//   IDLE_LEVEL           : level of the line when no frame is in flight
//   DEFAULT_CLKS_PER_BIT : default bit period in clock cycles
//   even_parity()        : parity bit that makes the frame's ones-count even
// Optional feature macro: UART_PARITY_EN (adds an even-parity bit; ST_PARITY
// is only reachable when it is defined).
package uart_pkg;

    localparam int   DATA_BITS            = 8;
    localparam logic START_BIT            = 1'b0;
    localparam logic STOP_BIT             = 1'b1;
    localparam logic IDLE_LEVEL           = 1'b1;
    localparam int   DEFAULT_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx: receive FSM, shift register and the rdy/dout output registers.
//   clk, rst_n : clock, asynchronous active-low reset
//   serial_i   : serial line from the transmitter (registered once here)
//   rdy_clr    : synchronous clear of rdy; a set in the same cycle wins
//   rdy        : sticky "dout holds a valid received byte"
//   dout       : last correctly framed byte
//   state_dbg  : current RX FSM state
// Optional feature macro: UART_PARITY_EN (check even parity before stop).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 serial_i,
    input  logic                 rdy_clr,
    output logic                 rdy,
    output logic [DATA_BITS-1:0] dout,
    output uart_state_e          state_dbg
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic                 line_q, line_d;
    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 rdy_q, rdy_d;
    logic                 par_err_q, par_err_d;
    logic                 byte_ok;

    always_comb begin
        line_d    = serial_i;
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        dout_d    = dout_q;
        par_err_d = par_err_q;
        byte_ok   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (line_q == START_BIT) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                // Mid start bit: a high line here was only a glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    idx_d     = '0;
                    par_err_d = 1'b0;
                    state_d   = (line_q == START_BIT) ? ST_DATA : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = line_q;
                    if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    par_err_d = (line_q != even_parity(shift_q));
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    // Framing or parity errors drop the byte silently.
                    if (line_q == STOP_BIT && !par_err_q) begin
                        dout_d  = shift_q;
                        byte_ok = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        rdy_d = rdy_q;
        if (rdy_clr) rdy_d = 1'b0;
        if (byte_ok) rdy_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q    <= IDLE_LEVEL;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            dout_q    <= '0;
            rdy_q     <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            line_q    <= line_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            dout_q    <= dout_d;
            rdy_q     <= rdy_d;
            par_err_q <= par_err_d;
        end
    end

    assign rdy       = rdy_q;
    assign dout      = dout_q;
    assign state_dbg = state_q;

endmodule

// File: rtl/uart_loopback_top.sv
// uart_loopback_top: 8N1 UART transmitter looped back into uart_rx.
//   clk          : single clock, rising edge
//   rst          : asynchronous active-low reset
//   data_in      : byte captured on an accepted wr_en
//   wr_en        : write strobe; only accepted while not busy (dropped otherwise)
//   rdy_clr      : synchronous clear of rdy
//   rdy, dout    : sticky received-byte flag and the byte itself
//   busy         : a TX frame is in flight
//   tx_state_dbg : TX FSM state;  rx_state_dbg : RX FSM state
//   tx_line_dbg  : registered serial line driven by the transmitter
// Handshake: a write is taken on any rising edge where wr_en=1 and busy=0;
// busy rises on that edge and drops on the edge that ends the stop bit.
// Optional feature macro: UART_PARITY_EN (11-bit frame with even parity).
module uart_loopback_top
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 wr_en,
    input  logic                 rdy_clr,
    output logic                 rdy,
    output logic                 busy,
    output logic [DATA_BITS-1:0] dout,
    output uart_state_e          tx_state_dbg,
    output uart_state_e          rx_state_dbg,
    output logic                 tx_line_dbg
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_e          tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 tx_line_q, tx_line_d;
    logic                 busy_q, busy_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_data_d  = tx_data_q;
        tx_line_d  = tx_line_q;
        busy_d     = busy_q;
        case (tx_state_q)
            ST_IDLE: begin
                // The start bit goes out on the accepting edge itself.
                if (wr_en) begin
                    tx_state_d = ST_START;
                    tx_data_d  = data_in;
                    tx_line_d  = START_BIT;
                    busy_d     = 1'b1;
                    tx_cnt_d   = '0;
                end
            end
            ST_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_line_d  = tx_data_q[0];
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        tx_line_d  = even_parity(tx_data_q);
                        tx_state_d = ST_PARITY;
`else
                        tx_line_d  = STOP_BIT;
                        tx_state_d = ST_STOP;
`endif
                    end else begin
                        tx_idx_d  = tx_idx_q + 3'd1;
                        tx_line_d = tx_data_q[tx_idx_q + 3'd1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            ST_PARITY: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_line_d  = STOP_BIT;
                    tx_state_d = ST_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    busy_d     = 1'b0;
                    tx_state_d = ST_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_data_q  <= '0;
            tx_line_q  <= IDLE_LEVEL;
            busy_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_data_q  <= tx_data_d;
            tx_line_q  <= tx_line_d;
            busy_q     <= busy_d;
        end
    end

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst),
        .serial_i (tx_line_q),
        .rdy_clr  (rdy_clr),
        .rdy      (rdy),
        .dout     (dout),
        .state_dbg(rx_state_dbg)
    );

    assign busy         = busy_q;
    assign tx_state_dbg = tx_state_q;
    assign tx_line_dbg  = tx_line_q;

endmodule

// File: tb/tb_uart_loopback_top.sv
// Directed bench for uart_loopback_top with an expected-byte queue.
module tb_uart_loopback_top;
    import uart_pkg::*;

    localparam int CPB = 16;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int BUSY_LEN = FRAME_BITS * CPB;
    // Accept edge to rdy-set edge: mid stop bit plus two register stages.
    localparam int RX_SET   = FRAME_BITS * CPB - CPB / 2 + 2;
    localparam int BUDGET   = 2 * BUSY_LEN;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        wr_en = 1'b0;
    logic        rdy_clr = 1'b0;
    logic        rdy;
    logic        busy;
    logic [7:0]  dout;
    uart_state_e tx_state_dbg;
    uart_state_e rx_state_dbg;
    logic        tx_line_dbg;

    int total = 0;
    int bad   = 0;
    int busy_run = 0;
    int last_busy_len = 0;
    logic [7:0] exp_q[$];

    uart_loopback_top #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .rdy_clr     (rdy_clr),
        .rdy         (rdy),
        .busy        (busy),
        .dout        (dout),
        .tx_state_dbg(tx_state_dbg),
        .rx_state_dbg(rx_state_dbg),
        .tx_line_dbg (tx_line_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // busy-length monitor, sampled on the falling edge
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            busy_run = 0;
        end else if (busy === 1'b1) begin
            busy_run++;
        end else if (busy_run != 0) begin
            last_busy_len = busy_run;
            busy_run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver: one write strobe, returns just after the accepting edge
    task automatic send(input logic [7:0] b, input bit expect_accept);
        @(negedge clk);
        data_in = b;
        wr_en   = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (expect_accept) exp_q.push_back(b);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        rdy_clr = 1'b1;
        @(posedge clk);
        #1;
        rdy_clr = 1'b0;
    endtask

    task automatic wait_busy_low();
        int n = 0;
        while (busy === 1'b1 && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("busy_timeout", {31'd0, busy}, 32'd0);
        @(negedge clk);
        #1;
    endtask

    // scoreboard pop
    task automatic pop_check(input string tag);
        logic [7:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s_queue observed=empty expected=byte", tag);
        end else begin
            total--;
            e = exp_q.pop_front();
            check(tag, {24'd0, dout}, {24'd0, e});
            check({tag, "_rdy"}, {31'd0, rdy}, 32'd1);
        end
    endtask

    initial begin
        logic [10:0] frame;
        logic [7:0]  b55;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rdy", {31'd0, rdy}, 32'd0);
        check("rst_dout", {24'd0, dout}, 32'h00);
        check("rst_line", {31'd0, tx_line_dbg}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_rdy", {31'd0, rdy}, 32'd0);

        // 0x41: frame length, receipt, clear
        send(8'h41, 1'b1);
        wait_busy_low();
        check("len_41", last_busy_len, BUSY_LEN);
        pop_check("rx_41");
        pulse_clr();
        check("clr_rdy", {31'd0, rdy}, 32'd0);
        check("clr_dout_kept", {24'd0, dout}, 32'h41);

        // 0x55: LSB-first bit order on the line
        b55 = 8'h55;
        frame = '1;
        frame[0] = START_BIT;
        for (int i = 0; i < 8; i++) frame[i + 1] = b55[i];
`ifdef UART_PARITY_EN
        frame[9]  = ^b55;
        frame[10] = STOP_BIT;
`else
        frame[9]  = STOP_BIT;
`endif
        send(b55, 1'b1);
        repeat (CPB / 2) @(posedge clk);
        #1;
        for (int k = 0; k < FRAME_BITS; k++) begin
            if (k != 0) begin
                repeat (CPB) @(posedge clk);
                #1;
            end
            check($sformatf("line_bit%0d", k), {31'd0, tx_line_dbg}, {31'd0, frame[k]});
        end
        wait_busy_low();
        pop_check("rx_55");

        // write while busy is dropped
        send(8'h0F, 1'b1);
        repeat (3 * CPB) @(posedge clk);
        @(negedge clk);
        data_in = 8'hFF;
        wr_en   = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        check("busy_mid_drop", {31'd0, busy}, 32'd1);
        wait_busy_low();
        check("len_0f", last_busy_len, BUSY_LEN);
        pop_check("rx_0f");
        repeat (BUSY_LEN) @(posedge clk);
        #1;
        check("no_ff_busy", {31'd0, busy}, 32'd0);
        check("no_ff_dout", {24'd0, dout}, 32'h0F);

        // back-to-back without clearing: overwrite, rdy stays high
        send(8'hA5, 1'b1);
        wait_busy_low();
        pop_check("rx_a5");
        send(8'h3C, 1'b1);
        wait_busy_low();
        pop_check("rx_3c");

        // clear in the set cycle: set wins
        pulse_clr();
        check("clr_before_set", {31'd0, rdy}, 32'd0);
        send(8'h77, 1'b1);
        repeat (RX_SET - 1) @(posedge clk);
        #1;
        check("rdy_before_set", {31'd0, rdy}, 32'd0);
        @(negedge clk);
        rdy_clr = 1'b1;
        @(posedge clk);
        #1;
        rdy_clr = 1'b0;
        pop_check("set_wins");
        check("busy_at_set", {31'd0, busy}, 32'd1);
        wait_busy_low();

        // reset mid-frame aborts everything
        send(8'h41, 1'b0);
        repeat (4 * CPB) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_rdy", {31'd0, rdy}, 32'd0);
        check("midrst_dout", {24'd0, dout}, 32'h00);
        check("midrst_line", {31'd0, tx_line_dbg}, 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (12 * CPB) @(posedge clk);
        #1;
        check("no_spurious_rdy", {31'd0, rdy}, 32'd0);
        check("no_spurious_busy", {31'd0, busy}, 32'd0);

        // recovery after reset
        send(8'h41, 1'b1);
        wait_busy_low();
        check("len_41_again", last_busy_len, BUSY_LEN);
        pop_check("rx_41_again");
        check("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
